// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: reset level, boolean and
// zero constants, access length codes, IO region tag and FSM/owner encodings.
package mem_ctrl_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        TRUE       = 1'b1;
    localparam logic        FALSE      = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic [2:0]  LEN_B = 3'b001;
    localparam logic [2:0]  LEN_H = 3'b010;
    localparam logic [2:0]  LEN_W = 3'b100;

    localparam logic [1:0]  IO_ADDR_HI_DEF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_IF  = 1'b1
    } owner_t;

    // Byte count for a length code; anything unrecognised is a full word.
    function automatic logic [2:0] len_to_bytes(input logic [2:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates MEM and IF requests and serialises each
// 1/2/4-byte access onto the byte-wide RAM/IO bus with a one-cycle done pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        mem_require_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [2:0]  mem_length_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_busy_o,
    output logic        mem_enable_o,
    output logic [31:0] mem_data_o,
    input  logic        if_require_i,
    input  logic [31:0] if_addr_i,
    output logic        if_busy_o,
    output logic        if_enable_o,
    output logic [31:0] if_data_o,
    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o,
    input  logic        io_buffer_full_i
);

    state_t      state_reg,  state_next;
    owner_t      owner_reg,  owner_next;
    logic        wr_reg,     wr_next;
    logic [31:0] addr_reg,   addr_next;
    logic [2:0]  nbytes_reg, nbytes_next;
    logic [2:0]  cnt_reg,    cnt_next;
    logic [31:0] data_reg,   data_next;

    logic        io_stall;
    logic        fire;
    logic [2:0]  byte_idx;
    logic [3:0]  cap_lane;

    assign io_stall = (addr_reg[17:16] == IO_ADDR_HI) && io_buffer_full_i;

    // One-hot lane select for the byte arriving on ram_din_i this cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign cap_lane[gi] = (state_reg == ST_READ) && (cnt_reg == 3'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= OWN_MEM;
            wr_reg     <= FALSE;
            addr_reg   <= ZERO_WORD;
            nbytes_reg <= 3'd0;
            cnt_reg    <= 3'd0;
            data_reg   <= ZERO_WORD;
        end else if (rdy) begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            wr_reg     <= wr_next;
            addr_reg   <= addr_next;
            nbytes_reg <= nbytes_next;
            cnt_reg    <= cnt_next;
            data_reg   <= data_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        wr_next     = wr_reg;
        addr_next   = addr_reg;
        nbytes_next = nbytes_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mem_require_i) begin
                    owner_next  = OWN_MEM;
                    wr_next     = mem_wr_i;
                    addr_next   = mem_addr_i;
                    nbytes_next = len_to_bytes(mem_length_i);
                    data_next   = mem_wr_i ? mem_data_i : ZERO_WORD;
                    cnt_next    = 3'd0;
                    state_next  = mem_wr_i ? ST_WRITE : ST_READ;
                end else if (if_require_i) begin
                    owner_next  = OWN_IF;
                    wr_next     = FALSE;
                    addr_next   = if_addr_i;
                    nbytes_next = len_to_bytes(LEN_W);
                    data_next   = ZERO_WORD;
                    cnt_next    = 3'd0;
                    state_next  = ST_READ;
                end
            end

            ST_READ: begin
                for (int k = 0; k < 4; k++) begin
                    if (cap_lane[k]) begin
                        data_next[8*k +: 8] = ram_din_i;
                    end
                end
                if (cnt_reg == nbytes_reg) begin
                    cnt_next   = 3'd0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end

            ST_WRITE: begin
                if (!io_stall) begin
                    if (cnt_reg == nbytes_reg - 3'd1) begin
                        cnt_next   = 3'd0;
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The RAM returns the byte for the address seen on the previous edge. While
    // frozen (and after the last address) re-present the byte still awaiting
    // capture so the returned data lines up with the counter when it resumes.
    always_comb begin
        byte_idx = cnt_reg;
        if ((state_reg == ST_READ) && (cnt_reg != 3'd0) &&
            ((cnt_reg == nbytes_reg) || !rdy)) begin
            byte_idx = cnt_reg - 3'd1;
        end
    end

    always_comb begin
        ram_a_o    = ZERO_WORD;
        ram_dout_o = 8'h00;
        ram_wr_o   = FALSE;
        if ((state_reg == ST_READ) || (state_reg == ST_WRITE)) begin
            ram_a_o = addr_reg + {29'd0, byte_idx};
        end
        if (state_reg == ST_WRITE) begin
            ram_dout_o = data_reg[{cnt_reg[1:0], 3'b000} +: 8];
            ram_wr_o   = rdy && !io_stall && (rst != RST_ENABLE);
        end
    end

    assign fire = (state_reg == ST_DONE) && rdy && (rst != RST_ENABLE);

    assign mem_busy_o   = (state_reg != ST_IDLE);
    assign if_busy_o    = (state_reg != ST_IDLE);
    assign mem_enable_o = fire && (owner_reg == OWN_MEM);
    assign if_enable_o  = fire && (owner_reg == OWN_IF);
    assign mem_data_o   = (mem_enable_o && !wr_reg) ? data_reg : ZERO_WORD;
    assign if_data_o    = if_enable_o ? data_reg : ZERO_WORD;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM environment plus a transaction-level golden
// memory; directed cases then randomized loads, stores, fetches and contention.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        mem_require_i, mem_wr_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic [2:0]  mem_length_i;
    logic        mem_busy_o, mem_enable_o;
    logic [31:0] mem_data_o;
    logic        if_require_i;
    logic [31:0] if_addr_i;
    logic        if_busy_o, if_enable_o;
    logic [31:0] if_data_o;
    logic [7:0]  ram_din_i, ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o, io_buffer_full_i;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_require_i(mem_require_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
        .mem_length_i(mem_length_i), .mem_data_i(mem_data_i),
        .mem_busy_o(mem_busy_o), .mem_enable_o(mem_enable_o), .mem_data_o(mem_data_o),
        .if_require_i(if_require_i), .if_addr_i(if_addr_i),
        .if_busy_o(if_busy_o), .if_enable_o(if_enable_o), .if_data_o(if_data_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o),
        .ram_wr_o(ram_wr_o), .io_buffer_full_i(io_buffer_full_i)
    );

    int checks = 0;
    int failures = 0;
    int wr_bad = 0;

    logic [7:0]  ram  [logic [31:0]];
    logic [7:0]  gold [logic [31:0]];
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5a;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : init_byte(a);
    endfunction

    // External byte RAM with one-cycle registered read.
    always @(posedge clk) begin
        ram_din_i <= ram_rd(ram_a_o);
        if (ram_wr_o) begin
            if (!rdy || rst) wr_bad++;
            ram[ram_a_o] = ram_dout_o;
            wlog_a.push_back(ram_a_o);
            wlog_d.push_back(ram_dout_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a]  = v;
        gold[a] = v;
    endtask

    function automatic int len_bytes(input logic [2:0] len);
        return (len == 3'b001) ? 1 : (len == 3'b010) ? 2 : 4;
    endfunction

    // Called in cycle 1 after the accepting edge; returns in the done cycle.
    task automatic serve(input bit is_mem, input bit wr, input logic [31:0] a, input int n,
                         input logic [31:0] d, input int stall, input int gap, input string tag);
        int lat, en_cyc, wbase;
        logic [31:0] exp, got;
        bit busy_bad, other_bad, addr_bad;
        lat = (wr ? n + 1 : n + 2) + gap + ((wr && a[17:16] == 2'b11) ? stall : 0);
        exp = 32'h0;
        if (!wr) for (int k = 0; k < n; k++) exp[8*k +: 8] = gold_rd(a + 32'(k));
        wbase = wlog_a.size();
        en_cyc = 0; got = 32'h0; busy_bad = 0; other_bad = 0; addr_bad = 0;
        for (int cyc = 1; cyc <= lat + 6 && en_cyc == 0; cyc++) begin
            io_buffer_full_i = (cyc <= stall);
            rdy = !(cyc >= 2 && cyc < 2 + gap);
            #1;
            if (!mem_busy_o || !if_busy_o) busy_bad = 1;
            if (is_mem ? if_enable_o : mem_enable_o) other_bad = 1;
            if (ram_a_o != 32'h0 && (ram_a_o - a) >= 32'(n)) addr_bad = 1;
            if (is_mem ? mem_enable_o : if_enable_o) begin
                en_cyc = cyc;
                got = is_mem ? mem_data_o : if_data_o;
            end else begin
                tick();
            end
        end
        io_buffer_full_i = 1'b0;
        rdy = 1'b1;
        chk({tag, "_lat"}, 32'(en_cyc), 32'(lat));
        chk({tag, "_data"}, got, exp);
        chk({tag, "_busy_other"}, {30'd0, busy_bad, other_bad}, 32'd0);
        chk({tag, "_addr_range"}, {31'd0, addr_bad}, 32'd0);
        chk({tag, "_nwrites"}, 32'(wlog_a.size() - wbase), wr ? 32'(n) : 32'd0);
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                if (wbase + k < wlog_a.size()) begin
                    chk({tag, "_wa"}, wlog_a[wbase + k], a + 32'(k));
                    chk({tag, "_wd"}, {24'd0, wlog_d[wbase + k]}, {24'd0, d[8*k +: 8]});
                end
                gold[a + 32'(k)] = d[8*k +: 8];
            end
        end
    endtask

    task automatic idle_check(input string tag);
        tick();
        #1;
        chk({tag, "_idle"}, {30'd0, mem_busy_o, if_busy_o}, 32'd0);
    endtask

    task automatic mem_txn(input bit wr, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] d, input int stall, input int gap, input string tag);
        mem_require_i = 1'b1; mem_wr_i = wr; mem_addr_i = a; mem_length_i = len; mem_data_i = d;
        tick();
        mem_require_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = $urandom; mem_data_i = $urandom;
        serve(1'b1, wr, a, len_bytes(len), d, stall, gap, tag);
        idle_check(tag);
    endtask

    task automatic if_txn(input logic [31:0] fa, input int gap, input string tag);
        if_require_i = 1'b1; if_addr_i = fa;
        tick();
        if_require_i = 1'b0; if_addr_i = $urandom;
        serve(1'b0, 1'b0, fa, 4, 32'h0, 0, gap, tag);
        idle_check(tag);
    endtask

    // MEM and IF raise require together; IF keeps requesting until accepted.
    task automatic dual_txn(input logic [31:0] a, input logic [2:0] len, input logic [31:0] fa,
                            input string tag);
        mem_require_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = a; mem_length_i = len;
        if_require_i = 1'b1; if_addr_i = fa;
        tick();
        mem_require_i = 1'b0;
        serve(1'b1, 1'b0, a, len_bytes(len), 32'h0, 0, 0, {tag, "_mem"});
        idle_check({tag, "_gap"});
        tick();
        if_require_i = 1'b0;
        serve(1'b0, 1'b0, fa, 4, 32'h0, 0, 0, {tag, "_if"});
        idle_check(tag);
    endtask

    logic [2:0]  len_tab [5];
    logic [31:0] ra, rd_w, rf;
    int          kind, rn, en_seen, wb;

    initial begin
        len_tab = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b000};
        rst = 1'b1; rdy = 1'b1; io_buffer_full_i = 1'b0;
        mem_require_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = 32'h0; mem_length_i = 3'b0;
        mem_data_i = 32'h0; if_require_i = 1'b0; if_addr_i = 32'h0;
        tick(); tick(); #1;
        chk("rst_ctl", 32'({mem_busy_o, if_busy_o, mem_enable_o, if_enable_o, ram_wr_o, ram_dout_o}), 32'd0);
        chk("rst_ram_a", ram_a_o, 32'h0);
        chk("rst_data", mem_data_o | if_data_o, 32'h0);
        rst = 1'b0;
        tick();

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        poke(32'h200, 8'h80);
        mem_txn(1'b0, 32'h100, 3'b100, 32'h0, 0, 0, "lw_100");
        mem_txn(1'b0, 32'h200, 3'b001, 32'h0, 0, 0, "lb_200");
        mem_txn(1'b1, 32'h300, 3'b010, 32'hDEADBEEF, 0, 0, "sh_300");
        mem_txn(1'b0, 32'h302, 3'b001, 32'h0, 0, 0, "lb_302");
        mem_txn(1'b0, 32'h300, 3'b010, 32'h0, 0, 0, "lh_300");
        dual_txn(32'h100, 3'b100, 32'h104, "dual");
        mem_txn(1'b1, 32'h30000, 3'b001, 32'h000000A5, 5, 0, "io_sb");
        mem_txn(1'b0, 32'h100, 3'b100, 32'h0, 0, 3, "lw_rdy");
        mem_txn(1'b1, 32'h140, 3'b100, 32'hCAFEF00D, 0, 2, "sw_rdy");

        // Reset while the third byte address of a word load is on the bus.
        mem_require_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 32'h100; mem_length_i = 3'b100;
        tick();
        mem_require_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_ctl", 32'({mem_busy_o, if_busy_o, mem_enable_o, if_enable_o, ram_wr_o, ram_dout_o}), 32'd0);
        chk("rstmid_ram_a", ram_a_o, 32'h0);
        en_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick(); #1;
            if (mem_enable_o || if_enable_o || mem_busy_o) en_seen = 1;
        end
        chk("rstmid_quiet", 32'(en_seen), 32'd0);

        // Reset after the first byte of a word store: no further writes.
        wb = wlog_a.size();
        mem_require_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h180; mem_length_i = 3'b100;
        mem_data_i = 32'h12345678;
        tick();
        mem_require_i = 1'b0; mem_wr_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gold[32'h180] = 8'h78;
        for (int c = 0; c < 6; c++) tick();
        chk("rstst_nwrites", 32'(wlog_a.size() - wb), 32'd1);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 5);
            ra   = 32'h100 + 32'($urandom_range(0, 127));
            rd_w = $urandom;
            rf   = 32'h100 + 32'($urandom_range(0, 127));
            rn   = $urandom_range(0, 4);
            case (kind)
                0, 1: mem_txn(1'b0, ra, len_tab[rn], 32'h0, 0, $urandom_range(0, 3), "r_load");
                2:    mem_txn(1'b1, ra, len_tab[rn], rd_w, $urandom_range(0, 2), $urandom_range(0, 3), "r_store");
                3:    mem_txn(1'b1, 32'h30000 + 32'($urandom_range(0, 15)), len_tab[rn], rd_w,
                              $urandom_range(0, 4), 0, "r_io");
                4:    if_txn(rf, $urandom_range(0, 3), "r_fetch");
                default: dual_txn(ra, len_tab[rn], rf, "r_dual");
            endcase
        end

        chk("no_wr_frozen", 32'(wr_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
